// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port synchronous memory.
// Data requests win by default; a burst counter lets a waiting fetch through after MAX_DATA_BURST data grants.
module mem_arbiter #(
    parameter int MAX_DATA_BURST = 4,
    parameter int MEM_DEPTH      = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        MemRd,
    output logic        MemWr,
    output logic        MemEnable,
    input  logic [31:0] mem_data_out,
    output logic        busy
);

    localparam int              CNT_W     = (MAX_DATA_BURST < 1) ? 1 : $clog2(MAX_DATA_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_DATA_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [31:0]     DEPTH     = 32'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state_r;
    logic             winner_d_r;
    logic             we_r;
    logic [CNT_W-1:0] burst_cnt_r;

    logic        i_elig_s;
    logic        d_elig_s;
    logic        open_s;
    logic        grant_i_s;
    logic        grant_d_s;
    logic        grant_we_s;
    logic [31:0] grant_addr_s;
    logic        in_range_s;

    // Arbitration; no grant is made in a cycle where either ack is still high.
    always_comb begin
        i_elig_s     = i_req && !i_ack;
        d_elig_s     = d_req && !d_ack;
        open_s       = (state_r == IDLE) && !i_ack && !d_ack;
        grant_i_s    = 1'b0;
        grant_d_s    = 1'b0;
        if (!open_s) begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end else if (i_elig_s && (!d_elig_s || (burst_cnt_r == BURST_MAX))) begin
            grant_i_s = 1'b1;
        end else if (d_elig_s) begin
            grant_d_s = 1'b1;
        end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end
        grant_addr_s = grant_d_s ? d_addr : i_addr;
        grant_we_s   = grant_d_s && d_we;
        in_range_s   = (grant_addr_s < DEPTH);
    end

    // Burst counter tracking consecutive data grants while a fetch is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt_r <= '0;
        end else if (!i_req || grant_i_s) begin
            burst_cnt_r <= '0;
        end else if (grant_d_s && (burst_cnt_r < BURST_MAX)) begin
            burst_cnt_r <= burst_cnt_r + CNT_ONE;
        end else begin
            burst_cnt_r <= burst_cnt_r;
        end
    end

    // Main FSM with registered memory strobes, acks, errors and read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            winner_d_r  <= 1'b0;
            we_r        <= 1'b0;
            busy        <= 1'b0;
            i_ack       <= 1'b0;
            d_ack       <= 1'b0;
            i_err       <= 1'b0;
            d_err       <= 1'b0;
            i_rdata     <= 32'd0;
            d_rdata     <= 32'd0;
            mem_address <= 32'd0;
            mem_data_in <= 32'd0;
            MemEnable   <= 1'b0;
            MemRd       <= 1'b0;
            MemWr       <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            i_err <= 1'b0;
            d_err <= 1'b0;
            case (state_r)
                IDLE: begin
                    if ((grant_i_s || grant_d_s) && in_range_s) begin
                        winner_d_r  <= grant_d_s;
                        we_r        <= grant_we_s;
                        mem_address <= grant_addr_s;
                        mem_data_in <= grant_d_s ? d_wdata : 32'd0;
                        MemEnable   <= 1'b1;
                        MemRd       <= !grant_we_s;
                        MemWr       <= grant_we_s;
                        busy        <= 1'b1;
                        state_r     <= ACCESS;
                    end else if (grant_i_s || grant_d_s) begin
                        // Out-of-range: answer immediately with an error, memory untouched.
                        i_ack <= grant_i_s;
                        i_err <= grant_i_s;
                        d_ack <= grant_d_s;
                        d_err <= grant_d_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    MemEnable <= 1'b0;
                    MemRd     <= 1'b0;
                    MemWr     <= 1'b0;
                    state_r   <= RESP;
                end
                RESP: begin
                    if (winner_d_r) begin
                        d_ack <= 1'b1;
                        if (!we_r) begin
                            d_rdata <= mem_data_out;
                        end else begin
                            d_rdata <= d_rdata;
                        end
                    end else begin
                        i_ack   <= 1'b1;
                        i_rdata <= mem_data_out;
                    end
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    MemEnable <= 1'b0;
                    MemRd     <= 1'b0;
                    MemWr     <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: synchronous memory model, reference memory image,
// directed scenarios and randomized single-port traffic.
module tb_mem_arbiter;

    localparam int MAXB  = 4;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack, i_err, d_err;
    logic [31:0] i_rdata, d_rdata;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        MemRd, MemWr, MemEnable, busy;

    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [31:0] bd_data;
    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];

    int n_checks = 0;
    int n_fail   = 0;
    int men_cnt  = 0;
    int i_ack_cnt = 0;
    int d_ack_cnt = 0;
    int viol     = 0;
    logic [31:0] last_i = 32'd0;
    logic [31:0] last_d = 32'd0;

    mem_arbiter #(.MAX_DATA_BURST(MAXB), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .MemRd(MemRd), .MemWr(MemWr), .MemEnable(MemEnable),
        .mem_data_out(mem_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous memory with a backdoor preload port.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (MemEnable && MemWr) begin
            mem[mem_address[7:0]] <= mem_data_in;
        end
        if (MemEnable && MemRd) begin
            mem_data_out <= mem[mem_address[7:0]];
        end
    end

    // Protocol monitor: samples the cycle that just ended.
    always @(posedge clk) begin
        if (MemEnable) men_cnt <= men_cnt + 1;
        if (i_ack) i_ack_cnt <= i_ack_cnt + 1;
        if (d_ack) d_ack_cnt <= d_ack_cnt + 1;
        if ((MemRd && MemWr) || (i_ack && d_ack) || ((MemEnable || MemRd || MemWr) && !busy))
            viol <= viol + 1;
    end

    task automatic preload();
        for (int i = 0; i < DEPTH; i++) begin
            bd_we   = 1'b1;
            bd_addr = i[7:0];
            bd_data = (i == 5) ? 32'h0000_1234 : $urandom;
            ref_mem[i] = bd_data;
            @(negedge clk);
        end
        bd_we = 1'b0;
    endtask

    task automatic do_op(input bit port_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat);
        lat = -1; rdata = 32'd0; err = 1'b0;
        if (port_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
        else begin i_req = 1'b1; i_addr = addr; end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (port_d ? d_ack : i_ack) begin
                lat = c; rdata = port_d ? d_rdata : i_rdata; err = port_d ? d_err : i_err;
                break;
            end
            if (port_d) begin d_addr = $urandom; d_wdata = $urandom; d_we = $urandom_range(0, 1); end
            else i_addr = $urandom;
        end
        if (port_d) d_req = 1'b0; else i_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({busy, i_ack, d_ack, i_err, d_err, MemEnable, MemRd, MemWr} !== 8'd0 ||
            mem_address !== 32'd0 || mem_data_in !== 32'd0 || i_rdata !== 32'd0 || d_rdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_hold: ctl=%b addr=%h rd=%h/%h, all zero required",
                {busy, i_ack, d_ack, i_err, d_err, MemEnable, MemRd, MemWr}, mem_address, i_rdata, d_rdata);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, i_ack, d_ack, MemEnable, MemRd, MemWr} !== 6'd0) begin
            n_fail++; $display("FAIL reset_release: ctl=%b, zero required", {busy, i_ack, d_ack, MemEnable, MemRd, MemWr});
        end
    endtask

    task automatic test_single_fetch();
        int m0;
        m0 = men_cnt;
        i_req = 1'b1; i_addr = 32'd5;
        @(negedge clk);
        n_checks++;
        if ({MemEnable, MemRd, MemWr, busy, i_ack} !== 5'b11010 || mem_address !== 32'd5) begin
            n_fail++; $display("FAIL fetch_access: en/rd/wr/busy/ack=%b addr=%0d, required 11010 addr 5",
                {MemEnable, MemRd, MemWr, busy, i_ack}, mem_address);
        end
        i_addr = 32'd77;
        @(negedge clk);
        n_checks++;
        if ({MemEnable, MemRd, busy, i_ack} !== 4'b0010) begin
            n_fail++; $display("FAIL fetch_resp: en/rd/busy/ack=%b, required 0010", {MemEnable, MemRd, busy, i_ack});
        end
        @(negedge clk);
        n_checks++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h1234 || i_err !== 1'b0) begin
            n_fail++; $display("FAIL fetch_ack: ack=%b rdata=%h err=%b, required 1 00001234 0", i_ack, i_rdata, i_err);
        end
        i_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (i_ack !== 1'b0 || i_rdata !== 32'h1234 || busy !== 1'b0 || men_cnt - m0 != 1) begin
            n_fail++; $display("FAIL fetch_after: ack=%b rdata=%h busy=%b en_cycles=%0d, required 0 1234 0 1",
                i_ack, i_rdata, busy, men_cnt - m0);
        end
        last_i = 32'h1234;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        do_op(1'b1, 1'b1, 32'd10, 32'hDEAD_BEEF, rd, er, lat);
        ref_mem[10] = 32'hDEAD_BEEF;
        n_checks++;
        if (lat != 3 || er !== 1'b0 || rd !== last_d) begin
            n_fail++; $display("FAIL store_ack: lat=%0d err=%b rdata=%h, required 3 0 %h", lat, er, rd, last_d);
        end
        do_op(1'b1, 1'b0, 32'd10, 32'h0, rd, er, lat);
        n_checks++;
        if (lat != 3 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL load_after_store: lat=%0d err=%b rdata=%h, required 3 0 deadbeef", lat, er, rd);
        end
        n_checks++;
        if (d_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL load_hold: d_rdata=%h, required deadbeef", d_rdata);
        end
        last_d = 32'hDEAD_BEEF;
    endtask

    task automatic test_range_error();
        logic [31:0] rd; logic er; int lat, m0;
        m0 = men_cnt;
        do_op(1'b1, 1'b1, 32'd300, 32'h0BAD_0BAD, rd, er, lat);
        n_checks++;
        if (lat != 1 || er !== 1'b1 || rd !== last_d || men_cnt != m0 || mem[44] !== ref_mem[44]) begin
            n_fail++; $display("FAIL range_store: lat=%0d err=%b rdata=%h en_cycles=%0d, required 1 1 %h 0",
                lat, er, rd, men_cnt - m0, last_d);
        end
        do_op(1'b0, 1'b0, 32'd256, 32'h0, rd, er, lat);
        n_checks++;
        if (lat != 1 || er !== 1'b1 || rd !== last_i || men_cnt != m0) begin
            n_fail++; $display("FAIL range_fetch256: lat=%0d err=%b rdata=%h, required 1 1 %h", lat, er, rd, last_i);
        end
        do_op(1'b0, 1'b0, 32'd255, 32'h0, rd, er, lat);
        n_checks++;
        if (lat != 3 || er !== 1'b0 || rd !== ref_mem[255]) begin
            n_fail++; $display("FAIL range_fetch255: lat=%0d err=%b rdata=%h, required 3 0 %h", lat, er, rd, ref_mem[255]);
        end
        last_i = ref_mem[255];
    endtask

    task automatic test_contention();
        bit got[$];
        bit exp_seq[$];
        int run = 0;
        for (int k = 0; k < 10; k++) begin
            if (run == MAXB) begin exp_seq.push_back(1'b0); run = 0; end
            else begin exp_seq.push_back(1'b1); run++; end
        end
        i_req = 1'b1; i_addr = 32'd30; d_req = 1'b1; d_we = 1'b0; d_addr = 32'd20;
        for (int c = 0; c < 200 && got.size() < 10; c++) begin
            @(negedge clk);
            if (d_ack) begin
                got.push_back(1'b1);
                n_checks++;
                if (d_rdata !== ref_mem[20]) begin
                    n_fail++; $display("FAIL contention_drdata: %h, required %h", d_rdata, ref_mem[20]);
                end
            end
            if (i_ack) begin
                got.push_back(1'b0);
                n_checks++;
                if (i_rdata !== ref_mem[30]) begin
                    n_fail++; $display("FAIL contention_irdata: %h, required %h", i_rdata, ref_mem[30]);
                end
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        n_checks++;
        if (got.size() != 10) begin
            n_fail++; $display("FAIL contention_count: %0d acks, required 10", got.size());
        end
        for (int k = 0; k < got.size() && k < 10; k++) begin
            n_checks++;
            if (got[k] !== exp_seq[k]) begin
                n_fail++; $display("FAIL contention_order[%0d]: grant %s, required %s", k,
                    got[k] ? "D" : "I", exp_seq[k] ? "D" : "I");
            end
        end
        repeat (4) @(negedge clk);
        last_i = ref_mem[30]; last_d = ref_mem[20];
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat, a0;
        i_req = 1'b1; i_addr = 32'd7;
        @(negedge clk);
        n_checks++;
        if (MemEnable !== 1'b1) begin
            n_fail++; $display("FAIL midrst_access: MemEnable=%b, required 1", MemEnable);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, i_ack, d_ack, i_err, d_err, MemEnable, MemRd, MemWr} !== 8'd0 ||
            mem_address !== 32'd0 || mem_data_in !== 32'd0 || i_rdata !== 32'd0 || d_rdata !== 32'd0) begin
            n_fail++; $display("FAIL midrst_async: ctl=%b addr=%h rd=%h/%h, all zero required",
                {busy, i_ack, d_ack, i_err, d_err, MemEnable, MemRd, MemWr}, mem_address, i_rdata, d_rdata);
        end
        i_req = 1'b0; a0 = i_ack_cnt;
        last_i = 32'd0; last_d = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (i_ack_cnt != a0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_noack: extra acks=%0d busy=%b, required 0 0", i_ack_cnt - a0, busy);
        end
        do_op(1'b0, 1'b0, 32'd7, 32'h0, rd, er, lat);
        n_checks++;
        if (lat != 3 || er !== 1'b0 || rd !== ref_mem[7]) begin
            n_fail++; $display("FAIL midrst_recover: lat=%0d err=%b rdata=%h, required 3 0 %h", lat, er, rd, ref_mem[7]);
        end
        last_i = ref_mem[7];
    endtask

    task automatic test_back_to_back();
        int d0, c;
        i_req = 1'b1; i_addr = 32'd40;
        c = 0;
        while (i_ack !== 1'b1 && c < 10) begin @(negedge clk); c++; end
        n_checks++;
        if (i_ack !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first_ack: no ack in 10 cycles");
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || MemEnable !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ack_cycle_grant: busy=%b en=%b, required 0 0", busy, MemEnable);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || MemEnable !== 1'b1) begin
            n_fail++; $display("FAIL b2b_regrant: busy=%b en=%b, required 1 1", busy, MemEnable);
        end
        d0 = d_ack_cnt;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd41; d_wdata = 32'h5555_AAAA;
        @(negedge clk);
        d_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (i_ack !== 1'b1 || i_rdata !== ref_mem[40]) begin
            n_fail++; $display("FAIL b2b_second_ack: ack=%b rdata=%h, required 1 %h", i_ack, i_rdata, ref_mem[40]);
        end
        @(negedge clk);
        i_req = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || d_ack_cnt != d0 || mem[41] !== ref_mem[41]) begin
            n_fail++; $display("FAIL b2b_drop: busy=%b extra d_acks=%0d mem41=%h, required 0 0 %h",
                busy, d_ack_cnt - d0, mem[41], ref_mem[41]);
        end
        last_i = ref_mem[40];
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wdata, exp_rd; logic er, exp_err; int lat, m0;
        bit port_d, we;
        for (int k = 0; k < 60; k++) begin
            port_d = $urandom_range(0, 1);
            we     = port_d & $urandom_range(0, 1);
            addr   = $urandom_range(0, 300);
            if ($urandom_range(0, 9) == 0) addr = $urandom | 32'h8000_0000;
            wdata  = $urandom;
            exp_err = (addr >= DEPTH);
            if (!exp_err && !we) exp_rd = ref_mem[addr[7:0]];
            else exp_rd = port_d ? last_d : last_i;
            m0 = men_cnt;
            do_op(port_d, we, addr, wdata, rd, er, lat);
            n_checks++;
            if (lat != (exp_err ? 1 : 3) || er !== exp_err || rd !== exp_rd || (men_cnt - m0) != (exp_err ? 0 : 1)) begin
                n_fail++; $display("FAIL random[%0d] %s we=%0d addr=%h: lat=%0d err=%b rdata=%h en=%0d, required lat=%0d err=%b rdata=%h",
                    k, port_d ? "D" : "I", we, addr, lat, er, rd, men_cnt - m0, exp_err ? 1 : 3, exp_err, exp_rd);
            end
            if (!exp_err && we) ref_mem[addr[7:0]] = wdata;
            if (port_d) last_d = exp_rd; else last_i = exp_rd;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
        bd_we = 1'b0; bd_addr = 8'd0; bd_data = 32'd0;
        @(negedge clk);
        preload();
        test_reset();
        test_single_fetch();
        test_store_load();
        test_range_error();
        test_contention();
        test_reset_mid();
        test_back_to_back();
        test_random();
        n_checks++;
        if (viol != 0) begin
            n_fail++; $display("FAIL protocol: %0d cycles with overlapping strobes/acks or strobes outside access", viol);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_DATA_BURST, default 4: consecutive data-port grants allowed while an instruction request waits.
REQ-002 Parameter MEM_DEPTH, default 256: number of valid word addresses in the memory.
REQ-003 clk  input  1: single clock, all state on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 i_req  input  1: instruction-fetch read request, held until i_ack.
REQ-006 i_addr  input  32: fetch word address.
REQ-007 i_ack  output  1: one-cycle fetch completion pulse.
REQ-008 i_rdata  output  32: fetch read data, valid while i_ack high, held afterwards.
REQ-009 i_err  output  1: address-range error, valid while i_ack high.
REQ-010 d_req  input  1: data-port request, held until d_ack.
REQ-011 d_we  input  1: 1 = store, 0 = load.
REQ-012 d_addr  input  32: data word address.
REQ-013 d_wdata  input  32: store data.
REQ-014 d_ack  output  1: one-cycle data completion pulse.
REQ-015 d_rdata  output  32: load data, valid while d_ack high, held afterwards; unchanged by stores.
REQ-016 d_err  output  1: address-range error, valid while d_ack high.
REQ-017 mem_address  output  32: memory address.
REQ-018 mem_data_in  output  32: memory write data.
REQ-019 MemRd  output  1: memory read strobe.
REQ-020 MemWr  output  1: memory write strobe.
REQ-021 MemEnable  output  1: memory enable.
REQ-022 mem_data_out  input  32: memory read data, registered in memory, valid the cycle after the read edge.
REQ-023 busy  output  1: high in every state except IDLE.

Function
REQ-024 FSM states are IDLE, ACCESS, RESP; all outputs are registered.
REQ-025 IDLE: a port is eligible if its req is high and its ack is low this cycle; a port whose ack is high in a cycle is ineligible in that cycle.
REQ-026 Arbitration: the data port wins over fetch, except when the burst counter equals MAX_DATA_BURST and fetch is eligible; then fetch wins.
REQ-027 Burst counter: +1 on each data grant while i_req is high; cleared on a fetch grant or whenever i_req is low; saturates at MAX_DATA_BURST.
REQ-028 On a grant with address < MEM_DEPTH: latch the winner, address, we and wdata; drive mem_address/mem_data_in; assert MemEnable plus MemWr (store) or MemRd (read); go to ACCESS.
REQ-029 ACCESS: hold the memory outputs for exactly one cycle so the memory acts on the edge ending ACCESS; deassert MemEnable/MemRd/MemWr on that edge; go to RESP.
REQ-030 RESP: on the edge ending RESP, load the winner's rdata from mem_data_out (reads only); pulse the winner's ack with err=0 in the following cycle; go to IDLE.
REQ-031 Read latency: req sampled in IDLE at edge N -> ack and rdata at cycle N+3; stores also ack at N+3.
REQ-032 On a grant with address >= MEM_DEPTH: no memory strobes are issued and the memory is unchanged; the FSM stays in IDLE; ack pulses the next cycle with err=1; rdata is unchanged.
REQ-033 MemEnable, MemRd and MemWr are never high outside ACCESS entry/hold; MemRd and MemWr are never high together.
REQ-034 At most one ack is high in any cycle; exactly one ack per granted request.
REQ-035 Requests arriving while busy wait; inputs are sampled only at grant, so later changes of addr/wdata do not affect an access in flight.
REQ-036 A req dropped before grant is discarded without a memory access.

Reset
REQ-037 rst_n low asynchronously forces: IDLE; busy, i_ack, d_ack, i_err, d_err, MemEnable, MemRd and MemWr all 0; mem_address, mem_data_in, i_rdata, d_rdata and the burst counter all 0.
REQ-038 Reset during ACCESS or RESP aborts the transaction: no ack is issued, and the first cycle after release is IDLE.

Verification
REQ-039 Single fetch: i_req with i_addr=5 and mem[5]=0x1234 -> MemRd/MemEnable high for one ACCESS cycle; i_ack with i_rdata=0x1234 three cycles after the grant; i_err=0.
REQ-040 Store then load: d_we=1, d_addr=10, d_wdata=0xDEADBEEF, then a load from 10 -> d_rdata=0xDEADBEEF; d_rdata is unchanged after the store ack.
REQ-041 Contention: i_req and d_req held continuously with d_req re-asserted after every d_ack -> grant sequence D,D,D,D,I,D,... with MAX_DATA_BURST=4.
REQ-042 Range error: d_addr=300 -> no MemEnable; d_ack with d_err=1 on the cycle after the grant; the memory contents are unchanged.
REQ-043 Reset mid-op: rst_n low during ACCESS of a fetch -> all outputs 0 immediately; no i_ack; a new request after release completes normally.
REQ-044 Back-to-back: a fetch held high through its ack is not re-granted in the ack cycle; it is re-granted the next cycle only if i_req is still high.
